// File: rtl/aimc_lib.sv
// Shared definitions for the outstanding-read ordering path.
package aimc_lib;

  localparam int unsigned ORDE_NUM_MAX_RD    = 512;
  localparam int unsigned ORDE_NUM_PER_BLOCK = 32;
  localparam int unsigned ORDE_ADDR_W        = 32;
  localparam int unsigned ORDE_DATA_W        = 256;
  localparam int unsigned ORDE_IDX_W         = $clog2(ORDE_NUM_MAX_RD);
  localparam int unsigned ORDE_PTR_W         = ORDE_IDX_W + 1;

  typedef logic [ORDE_IDX_W-1:0] orde_idx_t;

  // Retired entry as seen by the requester and the ordering-search path.
  typedef struct packed {
    orde_idx_t               idx;
    logic [ORDE_ADDR_W-1:0]  addr;
    logic [ORDE_DATA_W-1:0]  data;
  } orde_ret_t;

endpackage

// File: rtl/orde_rd_entry_ram.sv
// Per-entry payload storage: address written on allocation, data written on
// completion, both read asynchronously at the head index. No reset; contents
// are only consumed after both writes have happened for an entry.
module orde_rd_entry_ram #(
  parameter  int unsigned DEPTH  = 512,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 256,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_addr_we,
  input  logic [IDX_W-1:0]  i_addr_widx,
  input  logic [ADDR_W-1:0] i_addr_wdata,
  input  logic              i_data_we,
  input  logic [IDX_W-1:0]  i_data_widx,
  input  logic [DATA_W-1:0] i_data_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];

  // Independent write ports; the two arrays never collide.
  always_ff @(posedge i_clk) begin
    if (i_addr_we) r_addr_mem[i_addr_widx] <= i_addr_wdata;
    if (i_data_we) r_data_mem[i_data_widx] <= i_data_wdata;
  end

  assign o_raddr = r_addr_mem[i_ridx];
  assign o_rdata = r_data_mem[i_ridx];

endmodule

// File: rtl/orde_rd_tracker.sv
// In-order read tracker: circular table of outstanding reads, completed out of
// order, retired oldest-first through a single registered output stage.
module orde_rd_tracker
  import aimc_lib::*;
#(
  parameter  int unsigned NUM_MAX_RD = ORDE_NUM_MAX_RD,
  parameter  int unsigned ADDR_W     = ORDE_ADDR_W,
  parameter  int unsigned DATA_W     = ORDE_DATA_W,
  localparam int unsigned IDX_W      = $clog2(NUM_MAX_RD),
  localparam int unsigned PTR_W      = IDX_W + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alloc_valid,
  input  logic [ADDR_W-1:0]     i_alloc_addr,
  output logic                  o_alloc_ready,
  output logic [IDX_W-1:0]      o_alloc_idx,
  input  logic                  i_cmpl_valid,
  input  logic [IDX_W-1:0]      i_cmpl_idx,
  input  logic [DATA_W-1:0]     i_cmpl_data,
  output logic                  o_cmpl_err,
  output logic                  o_ret_valid,
  input  logic                  i_ret_ready,
  output logic [IDX_W-1:0]      o_ret_idx,
  output logic [ADDR_W-1:0]     o_ret_addr,
  output logic [DATA_W-1:0]     o_ret_data,
  output logic [IDX_W-1:0]      o_oldest_idx,
  output logic [NUM_MAX_RD-1:0] o_entry_valid,
  output logic [PTR_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(NUM_MAX_RD);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]      r_head, r_tail;
  logic [NUM_MAX_RD-1:0] r_valid, r_done;
  logic [NUM_MAX_RD-1:0] w_valid_d, w_done_d;
  logic                  r_ret_valid, r_cmpl_err;
  logic [IDX_W-1:0]      r_ret_idx;
  logic [ADDR_W-1:0]     r_ret_addr;
  logic [DATA_W-1:0]     r_ret_data;

  logic [PTR_W-1:0]  w_count;
  logic [IDX_W-1:0]  w_head_idx, w_tail_idx;
  logic              w_full, w_alloc_fire, w_cmpl_ok, w_load;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_count    = r_tail - r_head;
  assign w_full     = (w_count == FULL_CNT);

  assign w_alloc_fire = i_alloc_valid & ~w_full;
  // Legal only for a live, not-yet-done entry that is not being allocated now.
  assign w_cmpl_ok = i_cmpl_valid & r_valid[i_cmpl_idx] & ~r_done[i_cmpl_idx]
                   & ~(w_alloc_fire & (i_cmpl_idx == w_tail_idx));
  // Head moves into the output stage when done and the stage is free or draining.
  assign w_load = r_valid[w_head_idx] & r_done[w_head_idx] & (~r_ret_valid | i_ret_ready);

  orde_rd_entry_ram #(
    .DEPTH  (NUM_MAX_RD),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_entry_ram (
    .i_clk        (i_clk),
    .i_addr_we    (w_alloc_fire),
    .i_addr_widx  (w_tail_idx),
    .i_addr_wdata (i_alloc_addr),
    .i_data_we    (w_cmpl_ok),
    .i_data_widx  (i_cmpl_idx),
    .i_data_wdata (i_cmpl_data),
    .i_ridx       (w_head_idx),
    .o_raddr      (w_head_addr),
    .o_rdata      (w_head_data)
  );

  // Next state of the per-entry valid/done bits.
  always_comb begin
    w_valid_d = r_valid;
    w_done_d  = r_done;
    if (w_alloc_fire) begin
      w_valid_d[w_tail_idx] = 1'b1;
      w_done_d[w_tail_idx]  = 1'b0;
    end
    if (w_cmpl_ok) begin
      w_done_d[i_cmpl_idx] = 1'b1;
    end
    if (w_load) begin
      w_valid_d[w_head_idx] = 1'b0;
      w_done_d[w_head_idx]  = 1'b0;
    end
  end

  // Pointers and entry state bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_alloc_fire) r_tail <= r_tail + PTR_ONE;
      if (w_load)       r_head <= r_head + PTR_ONE;
      r_valid <= w_valid_d;
      r_done  <= w_done_d;
    end
  end

  // Retire output stage; fields hold while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ret_valid <= 1'b0;
      r_ret_idx   <= '0;
      r_ret_addr  <= '0;
      r_ret_data  <= '0;
    end else if (w_load) begin
      r_ret_valid <= 1'b1;
      r_ret_idx   <= w_head_idx;
      r_ret_addr  <= w_head_addr;
      r_ret_data  <= w_head_data;
    end else if (i_ret_ready) begin
      r_ret_valid <= 1'b0;
    end
  end

  // One-cycle pulse for a dropped completion.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cmpl_err <= 1'b0;
    else       r_cmpl_err <= i_cmpl_valid & ~w_cmpl_ok;
  end

  assign o_alloc_ready = ~w_full;
  assign o_alloc_idx   = w_tail_idx;
  assign o_cmpl_err    = r_cmpl_err;
  assign o_ret_valid   = r_ret_valid;
  assign o_ret_idx     = r_ret_idx;
  assign o_ret_addr    = r_ret_addr;
  assign o_ret_data    = r_ret_data;
  assign o_oldest_idx  = w_head_idx;
  assign o_entry_valid = r_valid;
  assign o_count       = w_count;
  assign o_full        = w_full;
  assign o_empty       = (w_count == '0);

endmodule

// File: tb/tb_orde_rd_tracker.sv
// Scoreboard bench for orde_rd_tracker: expected responses are queued at
// allocation time and popped by a monitor whenever a response transfers.
module tb_orde_rd_tracker;

  localparam int N = 512;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alloc_valid = 1'b0;
  logic [31:0]  alloc_addr = '0;
  logic         alloc_ready;
  logic [8:0]   alloc_idx;
  logic         cmpl_valid = 1'b0;
  logic [8:0]   cmpl_idx = '0;
  logic [255:0] cmpl_data = '0;
  logic         cmpl_err;
  logic         ret_valid;
  logic         ret_ready = 1'b1;
  logic [8:0]   ret_idx;
  logic [31:0]  ret_addr;
  logic [255:0] ret_data;
  logic [8:0]   oldest_idx;
  logic [N-1:0] entry_valid;
  logic [9:0]   count;
  logic         full, empty;

  orde_rd_tracker dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_alloc_valid (alloc_valid),
    .i_alloc_addr  (alloc_addr),
    .o_alloc_ready (alloc_ready),
    .o_alloc_idx   (alloc_idx),
    .i_cmpl_valid  (cmpl_valid),
    .i_cmpl_idx    (cmpl_idx),
    .i_cmpl_data   (cmpl_data),
    .o_cmpl_err    (cmpl_err),
    .o_ret_valid   (ret_valid),
    .i_ret_ready   (ret_ready),
    .o_ret_idx     (ret_idx),
    .o_ret_addr    (ret_addr),
    .o_ret_data    (ret_data),
    .o_oldest_idx  (oldest_idx),
    .o_entry_valid (entry_valid),
    .o_count       (count),
    .o_full        (full),
    .o_empty       (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]   idx;
    logic [31:0]  addr;
    logic [255:0] data;
  } exp_t;

  exp_t         q[$];
  logic [255:0] plan_data [N];
  logic [8:0]   exp_tail = '0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           err_pulses = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 1'b0;
    cmpl_valid = 1'b0;
    q.delete();
    exp_tail = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [31:0] addr);
    exp_t e;
    alloc_valid = 1'b1;
    alloc_addr  = addr;
    chk("alloc_ready", alloc_ready, 1);
    chk("alloc_idx", alloc_idx, exp_tail);
    e.idx  = exp_tail;
    e.addr = addr;
    e.data = {8{addr ^ 32'hA5A5_0000}};
    plan_data[exp_tail] = e.data;
    q.push_back(e);
    step();
    alloc_valid = 1'b0;
    exp_tail++;
  endtask

  task automatic do_cmpl(input logic [8:0] idx, input logic [255:0] data);
    cmpl_valid = 1'b1;
    cmpl_idx   = idx;
    cmpl_data  = data;
    step();
    cmpl_valid = 1'b0;
  endtask

  // Monitor: compare every transferred response against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmpl_err) err_pulses++;
      if (ret_valid && ret_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL ret_unexpected: got idx %0d, expected no response", ret_idx);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (ret_idx !== e.idx || ret_addr !== e.addr || ret_data !== e.data) begin
            n_errors++;
            $display("FAIL ret_payload: got idx %0d addr %0h data %0h, expected idx %0d addr %0h data %0h",
                     ret_idx, ret_addr, ret_data, e.idx, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_oldest", oldest_idx, 0);
    chk("rst_entry_valid", entry_valid, 0);
    chk("rst_cmpl_err", cmpl_err, 0);
    chk("rst_ret_fields", {ret_idx, ret_addr, ret_data}, 0);

    // Three allocations, completed in reverse order
    ret_ready = 1'b1;
    do_alloc(32'h100);
    do_alloc(32'h200);
    do_alloc(32'h300);
    chk("a3_count", count, 3);
    chk("a3_entry_valid", entry_valid, 3'b111);
    chk("a3_oldest", oldest_idx, 0);
    do_cmpl(9'd2, plan_data[2]);
    chk("ooo_no_ret_t", ret_valid, 0);
    do_cmpl(9'd1, plan_data[1]);
    chk("ooo_no_ret_t1", ret_valid, 0);
    do_cmpl(9'd0, plan_data[0]);
    chk("ooo_no_ret_t2", ret_valid, 0);
    step();
    chk("ooo_ret0_valid", ret_valid, 1);
    chk("ooo_ret0_idx", ret_idx, 0);
    step();
    chk("ooo_ret1_idx", ret_idx, 1);
    step();
    chk("ooo_ret2_idx", ret_idx, 2);
    step();
    chk("ooo_done_valid", ret_valid, 0);
    chk("ooo_empty", empty, 1);

    // Fill the table from index 0
    do_reset();
    for (int i = 0; i < N; i++) do_alloc(32'h1000 + 32'(i) * 4);
    chk("fill_full", full, 1);
    chk("fill_alloc_ready", alloc_ready, 0);
    chk("fill_count", count, 512);
    alloc_valid = 1'b1;
    alloc_addr  = 32'hDEAD;
    step();
    alloc_valid = 1'b0;
    chk("fill_blocked_count", count, 512);
    do_cmpl(9'd0, plan_data[0]);
    chk("fill_ready_still_low", alloc_ready, 0);
    step();
    chk("fill_ready_rises", alloc_ready, 1);
    chk("fill_wrap_idx", alloc_idx, 0);
    chk("fill_head", oldest_idx, 1);
    do_alloc(32'h7000);
    chk("fill_refull", full, 1);

    // Back-pressure: hold the output stage for 5 cycles
    ret_ready = 1'b0;
    do_cmpl(9'd1, plan_data[1]);
    do_cmpl(9'd2, plan_data[2]);
    do_cmpl(9'd3, plan_data[3]);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", ret_valid, 1);
      chk("stall_idx", ret_idx, 1);
      chk("stall_addr", ret_addr, 32'h1004);
      chk("stall_head", oldest_idx, 2);
      step();
    end
    ret_ready = 1'b1;
    step();
    chk("rel_idx2", {ret_valid, ret_idx}, {1'b1, 9'd2});
    step();
    chk("rel_idx3", {ret_valid, ret_idx}, {1'b1, 9'd3});
    step();
    chk("rel_drop", ret_valid, 0);
    chk("rel_count", count, 509);

    // Illegal completions
    do_reset();
    ret_ready = 1'b0;
    do_alloc(32'h500);
    do_alloc(32'h600);
    do_cmpl(9'd7, ~plan_data[7]);
    chk("err_unalloc", cmpl_err, 1);
    do_cmpl(9'd0, plan_data[0]);
    chk("err_legal", cmpl_err, 0);
    chk("err_no_ret_yet", ret_valid, 0);
    do_cmpl(9'd0, ~plan_data[0]);
    chk("err_dup", cmpl_err, 1);
    chk("err_ret_valid", {ret_valid, ret_idx}, {1'b1, 9'd0});
    step();
    chk("err_pulse_end", cmpl_err, 0);
    chk("err_entry_valid", entry_valid, 2'b10);
    chk("err_count", count, 1);
    chk("err_pulses", err_pulses, 2);
    ret_ready = 1'b1;
    step();

    // Asynchronous reset mid-stream
    do_reset();
    ret_ready = 1'b0;
    for (int i = 0; i < 11; i++) do_alloc(32'h8000 + 32'(i));
    do_cmpl(9'd0, plan_data[0]);
    step();
    chk("mid_ret_valid", ret_valid, 1);
    chk("mid_count", count, 10);
    #2 rst = 1'b1;
    #1;
    q.delete();
    exp_tail = '0;
    chk("async_ret_valid", ret_valid, 0);
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    chk("async_entry_valid", entry_valid, 0);
    chk("async_oldest", oldest_idx, 0);
    chk("async_ret_fields", {ret_idx, ret_addr, ret_data}, 0);
    chk("async_alloc_ready", alloc_ready, 1);
    step();
    rst = 1'b0;
    ret_ready = 1'b1;
    do_alloc(32'h9000);
    do_cmpl(9'd0, plan_data[0]);
    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    chk("drain_queue_empty", q.size(), 0);
    chk("final_err_pulses", err_pulses, 2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/orde_rd_tracker.md
# orde_rd_tracker

In-order read tracking table that allocates outstanding-read entries in a circular buffer of `NUM_MAX_RD` slots, marks them complete out of order, and retires them strictly oldest-first. It is the producer side of the ordering search path. It drives `oldest_idx` and the per-entry valid vector that the block-level match and ordering-search logic consume. It also supplies the in-order response stream back to the requester.

## Interface
- `NUM_MAX_RD`, 512, number of tracking entries (power of two)
- `NUM_PER_BLOCK`, 32, entries per search block (power of two, divides `NUM_MAX_RD`)
- `ADDR_W`, 32, stored request address width
- `DATA_W`, 256, completion/response data width
- Derived: `IDX_W = $clog2(NUM_MAX_RD)`, `PTR_W = IDX_W+1`
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alloc_valid`  in  1  request to allocate an entry
- `alloc_addr`  in  ADDR_W  address stored with the entry
- `alloc_ready`  out  1  entry available
- `alloc_idx`  out  IDX_W  index granted on the alloc handshake
- `cmpl_valid`  in  1  completion strobe (no back-pressure)
- `cmpl_idx`  in  IDX_W  entry being completed
- `cmpl_data`  in  DATA_W  completion payload
- `cmpl_err`  out  1  one-cycle pulse on an illegal completion
- `ret_valid`  out  1  retired response available
- `ret_ready`  in  1  consumer accepts response
- `ret_idx`, `ret_addr`, `ret_data`  out  IDX_W/ADDR_W/DATA_W  retired entry contents
- `oldest_idx`  out  IDX_W  head (oldest live) index
- `entry_valid`  out  NUM_MAX_RD  allocated-and-not-retired bit per entry
- `count`  out  PTR_W  number of live entries
- `full`, `empty`  out  1  occupancy flags

## Operation
- Pointers `head`, `tail` are PTR_W wide and wrap naturally. Index = low IDX_W bits. `count = tail - head` (modular). `full = (count == NUM_MAX_RD)`. `empty = (count == 0)`.
- Allocate:
  - `alloc_ready = !full`, from registered state; there is no same-cycle retire bypass.
  - `alloc_idx = tail[IDX_W-1:0]` combinationally.
  - On `alloc_valid & alloc_ready`: write `alloc_addr`, set `valid[idx]`, clear `done[idx]`, then `tail++`.
- Complete:
  - On `cmpl_valid` with `valid[cmpl_idx] & !done[cmpl_idx]`: write `cmpl_data` and set `done`.
  - Otherwise (entry not valid or already done): drop the completion and pulse `cmpl_err` the next cycle. The entry state is unchanged.
- Retire:
  - Single output register, `ret_valid` registered.
  - Load condition: `valid[head] & done[head] & (!ret_valid | ret_ready)`.
  - On load: capture index/addr/data, clear `valid[head]` and `done[head]`, then `head++`. `entry_valid[head]` falls at the same edge.
  - When `ret_valid & ret_ready` with no new load, `ret_valid` drops.
  - Output fields stay stable while `ret_valid & !ret_ready`.
- Simultaneous events:
  - Alloc and load in the same cycle: both take effect, and `count` is unchanged.
  - Completion to the head entry in cycle T: the load happens at edge T+1, not T.
  - A completion to the index being allocated in the same cycle is illegal: `cmpl_err` pulses.
- Reset (any time, including mid-operation):
  - `head = tail = 0`; all `valid`/`done` cleared.
  - `ret_valid = 0`, `cmpl_err = 0`, `oldest_idx = 0`, `count = 0`, `empty = 1`, `full = 0`, `alloc_ready = 1` after deassertion.
  - `ret_idx/addr/data` reset to 0. Any in-flight completions are discarded.

## Timing
- Alloc handshake at edge E: `entry_valid[idx]` and `count` update after E; the next `alloc_idx` is visible after E.
- Completion sampled at edge E0, head done, output free: load at E1, so `ret_valid` is high in the cycle after E1. Completion-to-response latency is 2 cycles.
- Sustained throughput with a ready consumer: 1 retire/cycle, 1 alloc/cycle.
- `oldest_idx` and `entry_valid` are registered state. The search logic sees a head change one cycle after the retire edge.

## Structure
- `aimc_lib` package holds:
  - `ORDE_NUM_MAX_RD`, `ORDE_NUM_PER_BLOCK`
  - typedef `orde_idx_t` (IDX_W)
  - struct `orde_ret_t` {idx, addr, data}, shared with the ordering-search path
- Sub-module `orde_rd_entry_ram`: two-write (alloc addr, cmpl data), one-read (head) storage with asynchronous read. It holds no reset.
- Valid/done bit vectors and pointers stay in the top module.

## Test plan
- Reset, then alloc 3 entries (addr 0x100/0x200/0x300): `alloc_idx` is 0,1,2; `count = 3`; `entry_valid = 0b111`; `oldest_idx = 0`.
- Complete idx 2, 1, 0 at cycles T, T+1, T+2:
  - No `ret_valid` before T+4.
  - Responses are then idx 0, 1, 2 in back-to-back cycles with matching addr/data.
  - `empty = 1` after the last.
- Fill 512 entries: `full = 1` and `alloc_ready = 0`. Retire one with `ret_ready = 1`: `alloc_ready` rises one cycle later. The next `alloc_idx = 0` (wrap), `head = 1`.
- Hold `ret_ready = 0` with head done: `ret_valid` and the fields stay stable for 5 cycles and `head` does not advance. Release: exactly one transfer per ready cycle.
- Complete idx 7 (never allocated), then complete idx 0 twice: `cmpl_err` pulses once for the first, once for the second duplicate, and the table is unaffected.
- Assert `rst` mid-stream with 10 live entries and `ret_valid = 1`: outputs return to their reset values immediately (async). After release, the first alloc gets idx 0.
